resp_tx_arbiter: RTL and testbench
==================================

# resp_tx_arbiter

Two-requester message arbiter sharing the transmit character FIFO (the path feeding `uart_tx`) between the command response generator (requester 0) and the asynchronous status/notification source (requester 1). Grants whole messages atomically, so characters from two sources never interleave. It forwards characters one per cycle while the FIFO has room. It also forces release of a runaway message after a programmable length.

## Interface
- `MAX_MSG_LEN`, default 32: maximum characters per grant; range 2..255.
- `clk_tx`  in  1  transmit-domain clock.
- `rst_clk_tx`  in  1  asynchronous, active-high reset.
- `req0_data`  in  8  requester 0 character.
- `req0_valid`  in  1  requester 0 character valid.
- `req0_last`  in  1  requester 0 final character of the message; qualified by `req0_valid`.
- `req0_ready`  out  1  requester 0 character accepted this cycle.
- `req1_data`, `req1_valid`, `req1_last`, `req1_ready`: identical to requester 0.
- `fifo_din`  out  8  character to the FIFO.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_full`  in  1  FIFO full flag.
- `grant`  out  2  one-hot owner; 2'b00 when idle.
- `msg_overrun`  out  1  one-cycle pulse on forced release.

## Operation
- FSM states: IDLE, OWN0, OWN1. Encoding is registered, and `grant` decodes directly from state.
- IDLE behaviour:
  - Only one valid requester: go to that requester's OWN state next cycle.
  - Both valid: the winner follows the arbitration policy (see Configuration).
  - Neither valid: stay in IDLE.
- OWNn transfer condition: `reqn_valid && !fifo_full`.
  - `reqn_ready` and `fifo_wr_en` are combinational from state, valid and full.
  - `fifo_din = reqn_data` during the owner's transfer.
  - The non-owner's ready is 0.
- Ownership is held while the owner's valid is low mid-message. Gaps are allowed, and there is no timeout on gaps.
- Transfer with `last=1`: go to IDLE at that edge and record the winner in `last_winner`.
- Length counter: 8-bit, cleared on entry to OWNn, incremented per transfer.
  - If a transfer would be the `MAX_MSG_LEN`-th and `last=0`, treat it as last: go to IDLE and pulse `msg_overrun` in the following cycle.
  - The requester's remaining characters re-arbitrate as a new message.
- A transfer with `last=1` exactly at the `MAX_MSG_LEN`-th character is normal and produces no overrun.
- `fifo_full` during OWNn stalls the transfer. The owner keeps its grant, and nothing is dropped.
- Reset, at any time including mid-message:
  - State = IDLE, `grant`=0, counter=0, `msg_overrun`=0, `last_winner`=1 (requester 0 wins the first tie).
  - All ready and write outputs are 0.
  - A partially sent message is not resumed.

## Timing
- Arbitration latency: valid seen in IDLE at edge k → `grant` at k+1 → earliest first transfer in cycle k+1.
- Throughput within a message: 1 char/cycle.
- Message-to-message gap: exactly one IDLE bubble cycle.
- `msg_overrun` is registered, high for the single cycle after the forcing transfer.
- Combinational paths: `reqn_valid`/`fifo_full` → `reqn_ready`/`fifo_wr_en`, and `reqn_data` → `fifo_din`. No other combinational paths.

## Configuration
- `TX_ARB_ROUND_ROBIN_EN` defined:
  - A tie in IDLE goes to the requester not equal to `last_winner`.
  - Two continuously valid requesters alternate messages.
- `TX_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: requester 0 always wins ties.
  - `last_winner` is still reset and updated but does not affect arbitration.

## Structure
- Shared package `tx_arb_pkg`:
  - FSM state localparams (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2).
  - Default `MAX_MSG_LEN`.
  - Character constants CR=8'h0D and LF=8'h0A, used by the bench for message framing.
- Sub-module `tx_msg_len_ctr`: clear/increment counter with a `at_max` compare output, parameterised on `MAX_MSG_LEN`.

## Test plan
- Req0 sends "OK\r\n" (4 chars, last on 8'h0A) with FIFO never full → grant=01 one cycle after valid; 4 consecutive writes 4F 4B 0D 0A; grant=00 the next cycle.
- Both requesters raise valid in the same cycle with 3-char messages each, round-robin enabled:
  - Order is req0 message, bubble, req1 message, bubble, req0 message.
  - With the macro undefined, req0 repeats whenever valid.
- Req1 mid-message with `fifo_full` held high for 5 cycles, while req0 is valid → no writes, req1 keeps grant=10 throughout, and req0_ready=0; the message resumes uncorrupted.
- Req0 streams 40 chars with no last, `MAX_MSG_LEN`=32 → forced release after char 32; `msg_overrun` pulses once; chars 33–40 sent after re-grant.
- Req0 sends exactly 32 chars with last on char 32 → `msg_overrun` stays 0.
- Assert `rst_clk_tx` asynchronously during char 2 of a req1 message → grant=00 and all ready/wr_en outputs 0 immediately. After release, a tie is granted to req0.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared definitions for the transmit-FIFO message arbiter: FSM encoding,
// default message length limit and the CR/LF framing characters.
package tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int unsigned TX_ARB_MAX_MSG_LEN = 32;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/tx_msg_len_ctr.sv
// Per-grant character counter; at_max flags that the next transfer is the
// MAX_MSG_LEN-th character of the current grant.
module tx_msg_len_ctr
   import tx_arb_pkg::*;
#(
   parameter int unsigned MAX_MSG_LEN = TX_ARB_MAX_MSG_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic at_max
);

   localparam logic [7:0] LAST_IDX = 8'(MAX_MSG_LEN - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + 8'd1;
   end

   assign at_max = (cnt == LAST_IDX);

endmodule

// File: rtl/resp_tx_arbiter.sv
// Two-requester whole-message arbiter in front of the uart_tx character FIFO.
// Define TX_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to requester 0.
module resp_tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int unsigned MAX_MSG_LEN = TX_ARB_MAX_MSG_LEN
) (
   input  logic       clk_tx,
   input  logic       rst_clk_tx,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] fifo_din,
   output logic       fifo_wr_en,
   input  logic       fifo_full,
   output logic [1:0] grant,
   output logic       msg_overrun
);

   arb_state_t state, state_d;
   logic       last_winner, last_winner_d;
   logic       overrun_d;
   logic       at_max;

   tx_msg_len_ctr #(
      .MAX_MSG_LEN(MAX_MSG_LEN)
   ) u_len_ctr (
      .clk   (clk_tx),
      .rst   (rst_clk_tx),
      .clr   (state == IDLE),
      .inc   (fifo_wr_en),
      .at_max(at_max)
   );

   always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
      if (rst_clk_tx) begin
         state       <= IDLE;
         last_winner <= 1'b1;
         msg_overrun <= 1'b0;
      end else begin
         state       <= state_d;
         last_winner <= last_winner_d;
         msg_overrun <= overrun_d;
      end
   end

   always_comb begin
      state_d       = state;
      last_winner_d = last_winner;
      overrun_d     = 1'b0;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;
      fifo_din      = '0;
      unique case (state)
         IDLE: begin
            if (req0_valid && req1_valid) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
               state_d = last_winner ? OWN0 : OWN1;
`else
               state_d = OWN0;
`endif
            end else if (req0_valid) begin
               state_d = OWN0;
            end else if (req1_valid) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            req0_ready = req0_valid && !fifo_full;
            fifo_din   = req0_data;
            // Hitting the length limit ends the grant even without last.
            if (req0_ready && (req0_last || at_max)) begin
               state_d       = IDLE;
               last_winner_d = 1'b0;
               overrun_d     = !req0_last;
            end
         end
         OWN1: begin
            req1_ready = req1_valid && !fifo_full;
            fifo_din   = req1_data;
            if (req1_ready && (req1_last || at_max)) begin
               state_d       = IDLE;
               last_winner_d = 1'b1;
               overrun_d     = !req1_last;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fifo_wr_en = req0_ready | req1_ready;
   assign grant      = {state == OWN1, state == OWN0};

endmodule

// File: tb/tb_resp_tx_arbiter.sv
// Self-checking bench for resp_tx_arbiter: per-requester expected-character
// queues plus per-cycle history of grant/write/ready/overrun.
module tb_resp_tx_arbiter;
   import tx_arb_pkg::*;

   localparam int unsigned MAXLEN = 32;

   logic       clk_tx = 1'b0;
   logic       rst_clk_tx = 1'b1;
   logic [7:0] req0_data = '0, req1_data = '0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_last = 1'b0, req1_last = 1'b0;
   logic       req0_ready, req1_ready;
   logic [7:0] fifo_din;
   logic       fifo_wr_en;
   logic       fifo_full = 1'b0;
   logic [1:0] grant;
   logic       msg_overrun;

   resp_tx_arbiter #(.MAX_MSG_LEN(MAXLEN)) dut (
      .clk_tx     (clk_tx),
      .rst_clk_tx (rst_clk_tx),
      .req0_data  (req0_data),
      .req0_valid (req0_valid),
      .req0_last  (req0_last),
      .req0_ready (req0_ready),
      .req1_data  (req1_data),
      .req1_valid (req1_valid),
      .req1_last  (req1_last),
      .req1_ready (req1_ready),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .grant      (grant),
      .msg_overrun(msg_overrun)
   );

   always #5 clk_tx = ~clk_tx;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   logic [8:0] src0[$], src1[$];
   logic [7:0] exp0[$], exp1[$];
   logic       hs0, hs1;

   logic [1:0] grant_h[0:4095];
   logic       wr_h[0:4095];
   logic       rdy0_h[0:4095];
   logic       rdy1_h[0:4095];
   logic       ovr_h[0:4095];

   task automatic push_char(input int r, input logic [7:0] d, input logic l);
      if (r == 0) begin
         src0.push_back({l, d});
         exp0.push_back(d);
      end else begin
         src1.push_back({l, d});
         exp1.push_back(d);
      end
   endtask

   task automatic push_msg3(input int r, input logic [7:0] d);
      push_char(r, d, 1'b0);
      push_char(r, CR, 1'b0);
      push_char(r, LF, 1'b1);
   endtask

   task automatic drive_inputs();
      req0_valid = (src0.size() > 0);
      req0_data  = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
      req0_last  = (src0.size() > 0) ? src0[0][8] : 1'b0;
      req1_valid = (src1.size() > 0);
      req1_data  = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
      req1_last  = (src1.size() > 0) ? src1[0][8] : 1'b0;
   endtask

   task automatic run_cycle();
      logic [7:0] e;
      @(negedge clk_tx);
      grant_h[cyc] = grant;
      wr_h[cyc]    = fifo_wr_en;
      rdy0_h[cyc]  = req0_ready;
      rdy1_h[cyc]  = req1_ready;
      ovr_h[cyc]   = msg_overrun;
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      if (fifo_wr_en) begin
         n_checks++;
         if (grant == 2'b01 && exp0.size() > 0) begin
            e = exp0.pop_front();
            if (fifo_din === e) n_pass++;
            else $display("FAIL sb_req0 cyc %0d: fifo_din=%h expected %h", cyc, fifo_din, e);
         end else if (grant == 2'b10 && exp1.size() > 0) begin
            e = exp1.pop_front();
            if (fifo_din === e) n_pass++;
            else $display("FAIL sb_req1 cyc %0d: fifo_din=%h expected %h", cyc, fifo_din, e);
         end else begin
            $display("FAIL sb_unexpected_write cyc %0d: grant=%b din=%h, no char expected", cyc, grant, fifo_din);
         end
      end
      @(posedge clk_tx);
      #1;
      cyc++;
      if (hs0 && src0.size() > 0) void'(src0.pop_front());
      if (hs1 && src1.size() > 0) void'(src1.pop_front());
      drive_inputs();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic flush_all();
      src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
      hs0 = 1'b0; hs1 = 1'b0;
      drive_inputs();
   endtask

   task automatic apply_reset();
      rst_clk_tx = 1'b1;
      flush_all();
      run_n(2);
      rst_clk_tx = 1'b0;
      run_n(1);
   endtask

   task automatic check_queues_empty(input string name);
      n_checks++;
      if (exp0.size() == 0 && exp1.size() == 0) n_pass++;
      else $display("FAIL %s_drain: pending exp0=%0d exp1=%0d, required 0/0", name, exp0.size(), exp1.size());
   endtask

   task automatic test_reset();
      rst_clk_tx = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      fifo_full  = 1'b0;
      #23;
      n_checks++;
      if (grant === 2'b00) n_pass++;
      else $display("FAIL reset_grant: got %b required 00", grant);
      n_checks++;
      if ({req0_ready, req1_ready, fifo_wr_en} === 3'b000) n_pass++;
      else $display("FAIL reset_outputs: rdy0/rdy1/wr=%b required 000", {req0_ready, req1_ready, fifo_wr_en});
      n_checks++;
      if (msg_overrun === 1'b0) n_pass++;
      else $display("FAIL reset_overrun: got %b required 0", msg_overrun);
      @(posedge clk_tx);
      #1;
      apply_reset();
   endtask

   task automatic test_ok_msg();
      int t0;
      push_char(0, 8'h4F, 1'b0);
      push_char(0, 8'h4B, 1'b0);
      push_char(0, CR, 1'b0);
      push_char(0, LF, 1'b1);
      drive_inputs();
      t0 = cyc;
      run_n(8);
      n_checks++;
      if (grant_h[t0] === 2'b00 && wr_h[t0] === 1'b0) n_pass++;
      else $display("FAIL ok_arb_cycle: grant=%b wr=%b required 00/0", grant_h[t0], wr_h[t0]);
      for (int i = 1; i <= 4; i++) begin
         n_checks++;
         if (grant_h[t0+i] === 2'b01 && wr_h[t0+i] === 1'b1) n_pass++;
         else $display("FAIL ok_write_%0d: grant=%b wr=%b required 01/1", i, grant_h[t0+i], wr_h[t0+i]);
      end
      n_checks++;
      if (grant_h[t0+5] === 2'b00 && wr_h[t0+5] === 1'b0) n_pass++;
      else $display("FAIL ok_release: grant=%b wr=%b required 00/0", grant_h[t0+5], wr_h[t0+5]);
      check_queues_empty("ok");
   endtask

   task automatic test_tie();
      int t0;
      logic [1:0] exp_g[11];
`ifdef TX_ARB_ROUND_ROBIN_EN
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};
`endif
      apply_reset();
      push_msg3(0, 8'h41);
      push_msg3(0, 8'h42);
      push_msg3(1, 8'h43);
      drive_inputs();
      t0 = cyc;
      run_n(14);
      for (int i = 0; i < 11; i++) begin
         n_checks++;
         if (grant_h[t0+1+i] === exp_g[i] && wr_h[t0+1+i] === (exp_g[i] != 2'b00)) n_pass++;
         else $display("FAIL tie_cycle_%0d: grant=%b wr=%b required %b", i + 1, grant_h[t0+1+i], wr_h[t0+1+i], exp_g[i]);
      end
      check_queues_empty("tie");
   endtask

   task automatic test_stall();
      int t1;
      for (int i = 0; i < 6; i++) push_char(1, 8'h60 + 8'(i), i == 5);
      drive_inputs();
      run_n(2);
      fifo_full = 1'b1;
      push_msg3(0, 8'h50);
      drive_inputs();
      t1 = cyc;
      run_n(5);
      fifo_full = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (wr_h[t1+i] === 1'b0 && grant_h[t1+i] === 2'b10 && rdy0_h[t1+i] === 1'b0 && rdy1_h[t1+i] === 1'b0)
            n_pass++;
         else
            $display("FAIL stall_%0d: wr=%b grant=%b rdy0=%b rdy1=%b required 0/10/0/0",
                     i, wr_h[t1+i], grant_h[t1+i], rdy0_h[t1+i], rdy1_h[t1+i]);
      end
      run_n(1);
      n_checks++;
      if (grant_h[t1+5] === 2'b10 && wr_h[t1+5] === 1'b1) n_pass++;
      else $display("FAIL stall_resume: grant=%b wr=%b required 10/1", grant_h[t1+5], wr_h[t1+5]);
      run_n(12);
      check_queues_empty("stall");
   endtask

   task automatic test_overrun();
      int t0, ovr_cnt;
      for (int i = 0; i < 40; i++) push_char(0, 8'h20 + 8'(i), 1'b0);
      drive_inputs();
      t0 = cyc;
      run_n(46);
      ovr_cnt = 0;
      for (int i = 0; i <= 45; i++) if (ovr_h[t0+i] === 1'b1) ovr_cnt++;
      n_checks++;
      if (ovr_cnt == 1) n_pass++;
      else $display("FAIL ovr_pulse_count: got %0d required 1", ovr_cnt);
      n_checks++;
      if (ovr_h[t0+33] === 1'b1 && grant_h[t0+33] === 2'b00) n_pass++;
      else $display("FAIL ovr_release: overrun=%b grant=%b required 1/00", ovr_h[t0+33], grant_h[t0+33]);
      n_checks++;
      if (wr_h[t0+32] === 1'b1 && grant_h[t0+34] === 2'b01 && wr_h[t0+34] === 1'b1) n_pass++;
      else $display("FAIL ovr_regrant: wr32=%b grant34=%b wr34=%b required 1/01/1", wr_h[t0+32], grant_h[t0+34], wr_h[t0+34]);
      check_queues_empty("ovr");
      apply_reset();
   endtask

   task automatic test_exact_max();
      int t0, ovr_cnt, wr_cnt;
      for (int i = 0; i < 32; i++) push_char(0, 8'h80 + 8'(i), i == 31);
      drive_inputs();
      t0 = cyc;
      run_n(37);
      ovr_cnt = 0;
      wr_cnt = 0;
      for (int i = 0; i <= 36; i++) begin
         if (ovr_h[t0+i] === 1'b1) ovr_cnt++;
         if (wr_h[t0+i] === 1'b1) wr_cnt++;
      end
      n_checks++;
      if (ovr_cnt == 0) n_pass++;
      else $display("FAIL exact_no_overrun: pulses=%0d required 0", ovr_cnt);
      n_checks++;
      if (wr_cnt == 32 && grant_h[t0+33] === 2'b00) n_pass++;
      else $display("FAIL exact_release: writes=%0d grant=%b required 32/00", wr_cnt, grant_h[t0+33]);
      check_queues_empty("exact");
   endtask

   task automatic test_async_reset();
      int t1;
      push_char(1, 8'h52, 1'b0);
      push_char(1, 8'h31, 1'b0);
      push_char(1, CR, 1'b0);
      push_char(1, LF, 1'b1);
      drive_inputs();
      run_n(2);
      n_checks++;
      if (fifo_wr_en === 1'b1 && req1_ready === 1'b1 && grant === 2'b10) n_pass++;
      else $display("FAIL areset_pre: wr=%b rdy1=%b grant=%b required 1/1/10", fifo_wr_en, req1_ready, grant);
      #2;
      rst_clk_tx = 1'b1;
      #1;
      n_checks++;
      if (grant === 2'b00 && {req0_ready, req1_ready, fifo_wr_en} === 3'b000) n_pass++;
      else $display("FAIL areset_immediate: grant=%b rdy0/rdy1/wr=%b required 00/000",
                    grant, {req0_ready, req1_ready, fifo_wr_en});
      @(posedge clk_tx);
      #1;
      flush_all();
      run_n(2);
      rst_clk_tx = 1'b0;
      push_msg3(0, 8'h54);
      push_msg3(1, 8'h55);
      drive_inputs();
      t1 = cyc;
      run_n(10);
      n_checks++;
      if (grant_h[t1+1] === 2'b01) n_pass++;
      else $display("FAIL areset_tie: grant=%b required 01", grant_h[t1+1]);
      n_checks++;
      if (grant_h[t1+5] === 2'b10) n_pass++;
      else $display("FAIL areset_second: grant=%b required 10", grant_h[t1+5]);
      check_queues_empty("areset");
   endtask

   initial begin
      hs0 = 1'b0;
      hs1 = 1'b0;
      test_reset();
      test_ok_msg();
      test_tie();
      test_stall();
      test_overrun();
      test_exact_max();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
